// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator behind a 2-entry skid buffer (output register + skid register).
// Optional feature: define IMM_GEN_CSR_ZIMM_EN to decode CSR-immediate forms as zimm (fmt 6).
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
   localparam logic [2:0] FMT_Z = 3'd6;
`endif

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } dec_t;

   // Immediates are assembled as signed 32-bit values, then widened so bit 31 sign-extends to XLEN.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t               d;
      logic signed [31:0] imm32;
      d     = '0;
      imm32 = '0;
      if (instr[1:0] != 2'b11) begin
         d.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
               d.fmt = FMT_I;
               imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
               if (instr[14]) begin
                  d.fmt = FMT_Z;
                  imm32 = {27'd0, instr[19:15]};
               end else begin
                  d.fmt = FMT_I;
                  imm32 = {{20{instr[31]}}, instr[31:20]};
               end
`else
               d.fmt = FMT_I;
               imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
            end
            7'b0100011: begin
               d.fmt = FMT_S;
               imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
               d.fmt = FMT_B;
               imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
               d.fmt = FMT_U;
               imm32 = {instr[31:12], 12'h000};
            end
            7'b1101111: begin
               d.fmt = FMT_J;
               imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110011: d.fmt = FMT_R;
            default:    d.illegal = 1'b1;
         endcase
      end
      d.imm = XLEN'(imm32);
      return d;
   endfunction

   dec_t             dec_p0;
   logic             in_fire;
   dec_t             skid_dec_p1;
   logic [TAG_W-1:0] skid_tag_p1;
   logic             skid_vld_p1;

   assign dec_p0  = decode(in_instr);
   assign in_fire = in_valid & in_ready;

   // ---- stage boundary: decode -> output / skid registers ----
   // in_ready mirrors "skid empty" as a register, so it never sees out_ready combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         skid_vld_p1 <= 1'b0;
         in_ready    <= 1'b1;
         out_imm     <= '0;
         out_fmt     <= '0;
         out_illegal <= 1'b0;
         out_tag     <= '0;
         skid_dec_p1 <= '0;
         skid_tag_p1 <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_vld_p1) begin
            out_imm     <= skid_dec_p1.imm;
            out_fmt     <= skid_dec_p1.fmt;
            out_illegal <= skid_dec_p1.illegal;
            out_tag     <= skid_tag_p1;
            out_valid   <= 1'b1;
            skid_vld_p1 <= 1'b0;
            in_ready    <= 1'b1;
         end else if (in_fire) begin
            out_imm     <= dec_p0.imm;
            out_fmt     <= dec_p0.fmt;
            out_illegal <= dec_p0.illegal;
            out_tag     <= in_tag;
            out_valid   <= 1'b1;
         end else begin
            out_valid   <= 1'b0;
         end
      end else if (in_fire) begin
         skid_dec_p1 <= dec_p0;
         skid_tag_p1 <= in_tag;
         skid_vld_p1 <= 1'b1;
         in_ready    <= 1'b0;
      end
   end

endmodule
